riscv_dm_wb_slave: RTL
======================

# riscv_dm_wb_slave

Wishbone classic slave implementing a minimal RISC-V External Debug Module register set (DMI addresses 0x04, 0x10, 0x11, 0x16, 0x17). It sits directly downstream of the wishbone master that the JTAG TAP drives on DMI scans, and it converts register writes into halt/resume requests and abstract GPR-access handshakes toward the core. One command engine (IDLE/ISSUE) serialises abstract commands, with cmderr reporting.

## Interface
- `TIMEOUT_CYCLES`, 1024: abort limit for an abstract command handshake (used only with `DM_CMD_TIMEOUT_EN`).
- `clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `addr_i` in 32: `[6:0]` is the DMI register address; `[31:7]` ignored.
- `we_i` in 1: write enable.
- `data_i` in 32: write data.
- `cyc_i`, `stb_i` in 1 each: wishbone cycle and strobe.
- `data_o` out 32: read data, valid while `ack_o`=1.
- `ack_o` out 1: registered one-cycle acknowledge.
- `halt_req_o` out 1: halt request to the core, level.
- `resume_req_o` out 1: resume request to the core, level.
- `ndmreset_o` out 1: system reset request, from dmcontrol.ndmreset.
- `halted_i`, `running_i` in 1 each: core run state.
- `ar_valid_o` out 1: abstract register access request.
- `ar_write_o` out 1: 1 = write GPR, 0 = read.
- `ar_regno_o` out 5: GPR index (regno[4:0]).
- `ar_wdata_o` out 32: write data (data0).
- `ar_ready_i` in 1: core accepts/completes the access.
- `ar_rdata_i` in 32: GPR read data, valid with `ar_ready_i`.

## Operation
- Request `req = cyc_i & stb_i & ~ack_o`. A write takes effect at the edge where `ack_o` goes high.
- Unmapped addresses read 0 and ignore writes.
- **data0 (0x04)** RW 32 bits. A write while busy sets cmderr=1 and is ignored.
- **dmcontrol (0x10)**: bit31 haltreq, bit30 resumereq (write-only, reads 0), bit1 ndmreset, bit0 dmactive.
  - While dmactive=0, writes update only dmactive. data0, cmderr, haltreq, ndmreset and resume state are held at reset values, and the engine is forced to IDLE.
- **dmstatus (0x11)** RO:
  - [17:16] allresumeack/anyresumeack = resumeack.
  - [11:10] allrunning/anyrunning = `running_i`.
  - [9:8] allhalted/anyhalted = `halted_i`.
  - [7] authenticated = 1.
  - [3:0] version = 2.
  - All other bits 0.
- **abstractcs (0x16)**: [28:24] progbufsize=0, [12] busy, [10:8] cmderr (write-1-to-clear per bit), [3:0] datacount=1.
- **command (0x17)**: fields cmdtype[31:24], aarsize[22:20], transfer[17], write[16], regno[15:0]. Checks are applied in this order:
  1. cmderr≠0: ignored, no change.
  2. busy: cmderr=1.
  3. cmdtype≠0, aarsize≠2, or (transfer=1 and regno∉0x1000–0x101F): cmderr=2.
  4. `halted_i`=0: cmderr=4.
  5. transfer=0: completes immediately, busy never set.
  6. Otherwise the engine goes to ISSUE.
- **Engine**:
  - IDLE→ISSUE on an accepted command. ISSUE latches write and regno[4:0].
  - ISSUE: `ar_valid_o`=1 until a cycle with `ar_ready_i`=1. On that cycle, a read loads data0←`ar_rdata_i`, then the engine returns to IDLE.
  - busy = (state==ISSUE).
- **Halt/resume**:
  - `halt_req_o` = haltreq & dmactive.
  - A resumereq=1 write with dmactive=1 and haltreq=0 sets resume_pending and clears resumeack.
  - `resume_req_o` = resume_pending.
  - While pending, `running_i`=1 clears pending and sets resumeack.
  - resumereq together with haltreq=1 is ignored.

## Timing
- All outputs reset to 0: `data_o`, `ack_o`, `halt_req_o`, `resume_req_o`, `ndmreset_o`, `ar_valid_o`, `ar_write_o`, `ar_regno_o`, `ar_wdata_o`. Internal state: IDLE, cmderr=0, data0=0, resumeack=0.
- Ack latency is one cycle: request sampled at edge N gives `ack_o`=1 after edge N, cleared after edge N+1. Holding `stb_i` yields an ack every other cycle.
- A command write acked at edge N gives `ar_valid_o`=1 and busy=1 from edge N onward. Handshake at edge M gives busy=0 and the data0 update visible after edge M.
- A read of data0 in the same cycle as a completing handshake returns the old value.
- `ar_wdata_o` is sampled from data0 at command acceptance and held stable during ISSUE.
- If asynchronous reset asserts mid-command, all state clears immediately and `ar_valid_o` drops without a handshake.

## Configuration
- `DM_CMD_TIMEOUT_EN` defined:
  - A counter runs in ISSUE.
  - If `ar_ready_i` has not been seen after `TIMEOUT_CYCLES` cycles in ISSUE, the engine returns to IDLE with cmderr=3 and data0 unchanged.
  - The counter clears on entry to ISSUE.
- Undefined: no counter is built, and ISSUE waits indefinitely.

## Test plan
- **Basic access**: after reset, read 0x11 → 0x0000_0082 (`halted_i`=`running_i`=0). Write 0x04=0xDEADBEEF, read 0x04 → 0xDEADBEEF.
- **Halt/resume**:
  - Write 0x10=0x8000_0001 → `halt_req_o`=1. Set `halted_i`=1 → dmstatus[9:8]=2'b11.
  - Write 0x10=0x4000_0001 → `resume_req_o`=1. Raise `running_i` → `resume_req_o`=0 next cycle and dmstatus[17:16]=2'b11.
- **GPR read**: halted, write 0x17=0x0022_1005 → `ar_valid_o`=1, `ar_regno_o`=5, `ar_write_o`=0. Ready after 3 cycles with `ar_rdata_i`=0x1234 → data0=0x1234, busy=0.
- **Errors**:
  - Command write while busy → cmderr=1. A further command is ignored.
  - Write 0x16=0x700 → cmderr=0.
  - Command 0x0132_1000 → cmderr=2.
  - Command with `halted_i`=0 → cmderr=4.
- **dmactive=0**: with data0=5 and haltreq=1, write 0x10=0 → data0=0, `halt_req_o`=0. A command is ignored.
- **Timeout** (`DM_CMD_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8): `ar_ready_i` held 0 → returns to IDLE after 8 cycles with cmderr=3.

Source files
------------

// File: rtl/riscv_dm_wb_slave.sv
// Wishbone classic slave exposing a minimal RISC-V debug module register set and abstract GPR access.
// Optional DM_CMD_TIMEOUT_EN aborts an abstract command that gets no ar_ready_i within TIMEOUT_CYCLES.
`default_nettype none

module riscv_dm_wb_slave #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [31:0] data_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        halt_req_o,
    output logic        resume_req_o,
    output logic        ndmreset_o,
    input  logic        halted_i,
    input  logic        running_i,
    output logic        ar_valid_o,
    output logic        ar_write_o,
    output logic [4:0]  ar_regno_o,
    output logic [31:0] ar_wdata_o,
    input  logic        ar_ready_i,
    input  logic [31:0] ar_rdata_i
);
    // state | meaning
    // IDLE  | no abstract command outstanding
    // ISSUE | ar_valid_o asserted, waiting for ar_ready_i (or timeout)
    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    localparam logic [6:0] ADDR_DATA0      = 7'h04;
    localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
    localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
    localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
    localparam logic [6:0] ADDR_COMMAND    = 7'h17;

    state_e      state_q, state_d;
    logic        ack_q, ack_d;
    logic [31:0] data_o_q, data_o_d;
    logic [31:0] data0_q, data0_d;
    logic [2:0]  cmderr_q, cmderr_d;
    logic        dmactive_q, dmactive_d;
    logic        haltreq_q, haltreq_d;
    logic        ndmreset_q, ndmreset_d;
    logic        resume_pending_q, resume_pending_d;
    logic        resumeack_q, resumeack_d;
    logic        ar_write_q, ar_write_d;
    logic [4:0]  ar_regno_q, ar_regno_d;
    logic [31:0] ar_wdata_q, ar_wdata_d;

    logic        req;
    logic        busy;
    logic        cmd_bad;
    logic [6:0]  reg_addr;
    logic [31:0] rdata;

`ifdef DM_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] timer_q, timer_d;
    logic          unused_bits;
    assign unused_bits = ^addr_i[31:7];
`else
    logic          unused_bits;
    assign unused_bits = ^{addr_i[31:7], (TIMEOUT_CYCLES > 0)};
`endif

    assign req      = cyc_i & stb_i & ~ack_q;
    assign busy     = (state_q == ISSUE);
    assign reg_addr = addr_i[6:0];
    // Legal transfers target GPRs only: regno 0x1000..0x101F.
    assign cmd_bad  = (data_i[31:24] != 8'h00) || (data_i[22:20] != 3'd2) ||
                      (data_i[17] && (data_i[15:5] != 11'h080));

    always_comb begin
        rdata = 32'h0;
        case (reg_addr)
            ADDR_DATA0:      rdata = data0_q;
            ADDR_DMCONTROL:  rdata = {haltreq_q, 1'b0, 28'd0, ndmreset_q, dmactive_q};
            ADDR_DMSTATUS:   rdata = {14'd0, {2{resumeack_q}}, 4'd0, {2{running_i}},
                                      {2{halted_i}}, 1'b1, 3'd0, 4'd2};
            ADDR_ABSTRACTCS: rdata = {19'd0, busy, 1'b0, cmderr_q, 4'd0, 4'd1};
            default:         rdata = 32'h0;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        ack_d            = req;
        data_o_d         = 32'h0;
        data0_d          = data0_q;
        cmderr_d         = cmderr_q;
        dmactive_d       = dmactive_q;
        haltreq_d        = haltreq_q;
        ndmreset_d       = ndmreset_q;
        resume_pending_d = resume_pending_q;
        resumeack_d      = resumeack_q;
        ar_write_d       = ar_write_q;
        ar_regno_d       = ar_regno_q;
        ar_wdata_d       = ar_wdata_q;
`ifdef DM_CMD_TIMEOUT_EN
        timer_d          = timer_q;
`endif

        if (resume_pending_q && running_i) begin
            resume_pending_d = 1'b0;
            resumeack_d      = 1'b1;
        end

        if (req && !we_i) begin
            data_o_d = rdata;
        end else if (req && we_i && !dmactive_q) begin
            if (reg_addr == ADDR_DMCONTROL) dmactive_d = data_i[0];
        end else if (req && we_i) begin
            case (reg_addr)
                ADDR_DATA0: begin
                    if (busy) cmderr_d = 3'd1;
                    else      data0_d  = data_i;
                end
                ADDR_DMCONTROL: begin
                    dmactive_d = data_i[0];
                    haltreq_d  = data_i[31];
                    ndmreset_d = data_i[1];
                    if (data_i[30] && !data_i[31]) begin
                        resume_pending_d = 1'b1;
                        resumeack_d      = 1'b0;
                    end
                end
                ADDR_ABSTRACTCS: cmderr_d = cmderr_q & ~data_i[10:8];
                ADDR_COMMAND: begin
                    if (cmderr_q == 3'd0) begin
                        if (busy)               cmderr_d = 3'd1;
                        else if (cmd_bad)       cmderr_d = 3'd2;
                        else if (!halted_i)     cmderr_d = 3'd4;
                        else if (data_i[17]) begin
                            state_d    = ISSUE;
                            ar_write_d = data_i[16];
                            ar_regno_d = data_i[4:0];
                            ar_wdata_d = data0_q;
`ifdef DM_CMD_TIMEOUT_EN
                            timer_d    = TW'(TIMEOUT_CYCLES - 1);
`endif
                        end
                    end
                end
                default: ;
            endcase
        end

        // Engine runs after the bus so a timeout error wins over a same-cycle cmderr write.
        if (state_q == ISSUE) begin
            if (ar_ready_i) begin
                state_d = IDLE;
                if (!ar_write_q) data0_d = ar_rdata_i;
            end
`ifdef DM_CMD_TIMEOUT_EN
            else if (timer_q == '0) begin
                state_d  = IDLE;
                cmderr_d = 3'd3;
            end else begin
                timer_d = timer_q - 1'b1;
            end
`endif
        end

        if (!dmactive_d) begin
            state_d          = IDLE;
            data0_d          = 32'h0;
            cmderr_d         = 3'd0;
            haltreq_d        = 1'b0;
            ndmreset_d       = 1'b0;
            resume_pending_d = 1'b0;
            resumeack_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            ack_q            <= 1'b0;
            data_o_q         <= 32'h0;
            data0_q          <= 32'h0;
            cmderr_q         <= 3'd0;
            dmactive_q       <= 1'b0;
            haltreq_q        <= 1'b0;
            ndmreset_q       <= 1'b0;
            resume_pending_q <= 1'b0;
            resumeack_q      <= 1'b0;
            ar_write_q       <= 1'b0;
            ar_regno_q       <= 5'd0;
            ar_wdata_q       <= 32'h0;
`ifdef DM_CMD_TIMEOUT_EN
            timer_q          <= '0;
`endif
        end else begin
            state_q          <= state_d;
            ack_q            <= ack_d;
            data_o_q         <= data_o_d;
            data0_q          <= data0_d;
            cmderr_q         <= cmderr_d;
            dmactive_q       <= dmactive_d;
            haltreq_q        <= haltreq_d;
            ndmreset_q       <= ndmreset_d;
            resume_pending_q <= resume_pending_d;
            resumeack_q      <= resumeack_d;
            ar_write_q       <= ar_write_d;
            ar_regno_q       <= ar_regno_d;
            ar_wdata_q       <= ar_wdata_d;
`ifdef DM_CMD_TIMEOUT_EN
            timer_q          <= timer_d;
`endif
        end
    end

    assign ack_o        = ack_q;
    assign data_o       = data_o_q;
    assign halt_req_o   = haltreq_q & dmactive_q;
    assign resume_req_o = resume_pending_q;
    assign ndmreset_o   = ndmreset_q;
    assign ar_valid_o   = (state_q == ISSUE);
    assign ar_write_o   = ar_write_q;
    assign ar_regno_o   = ar_regno_q;
    assign ar_wdata_o   = ar_wdata_q;

endmodule

`default_nettype wire
